// File: rtl/arm_pipe_pkg.sv
// Shared pipeline-control types: stall/flush FSM states and default counter width.
package arm_pipe_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RECOVER  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter
    import arm_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stall_flush_controller.sv
// Pipeline stall/flush controller: memory-miss freeze FSM, branch flush, hazard
// bubble, sticky memory-timeout flag and saturating stall/flush counters.
module stall_flush_controller
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             freeze_if,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output pipe_state_t      state
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic              miss;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    assign miss     = mem_req && !sram_ready;
    assign wait_nxt = wait_cnt + WAIT_W'(1);

    // Freeze drops in the very cycle the memory answers; RECOVER never freezes.
    always_comb begin
        freeze_all   = ((state == MEM_WAIT) && !sram_ready) || ((state == RUN) && miss);
        freeze_if    = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (!freeze_all) begin
            if (branch_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (hazard_detected) begin
                freeze_if    = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (miss) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // Count holds at the limit; the flag is sticky and waiting goes on.
                    if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_nxt;
                    if (wait_nxt == WAIT_LIMIT) mem_timeout <= 1'b1;
                    if (sram_ready) state <= RECOVER;
                end
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_if || freeze_all),
        .clear (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id),
        .clear (1'b0),
        .count (flush_count)
    );

endmodule

// File: tb/tb_stall_flush_controller.sv
// Bench for stall_flush_controller: two instances (wide and 2-bit counters)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_stall_flush_controller;
    import arm_pipe_pkg::*;

    localparam int TO     = 4;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_detected = 1'b0;
    logic branch_taken    = 1'b0;
    logic mem_req         = 1'b0;
    logic sram_ready      = 1'b0;

    logic        fi_a, fl_a, bb_a, fa_a, to_a;
    logic [15:0] sc_a, fc_a;
    pipe_state_t st_a;
    logic        fi_b, fl_b, bb_b, fa_b, to_b;
    logic [1:0]  sc_b, fc_b;
    pipe_state_t st_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stall_flush_controller #(.MEM_TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
        .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
        .freeze_if(fi_a), .flush_if_id(fl_a), .bubble_id_ex(bb_a),
        .freeze_all(fa_a), .mem_timeout(to_a), .stall_cycles(sc_a),
        .flush_count(fc_a), .state(st_a)
    );

    stall_flush_controller #(.CNT_W(2), .MEM_TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
        .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
        .freeze_if(fi_b), .flush_if_id(fl_b), .bubble_id_ex(bb_b),
        .freeze_all(fa_b), .mem_timeout(to_b), .stall_cycles(sc_b),
        .flush_count(fc_b), .state(st_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_wait = 0;
    bit m_rec  = 0;
    bit m_to   = 0;
    int m_wlen = 0;
    int m_sc_a = 0, m_fc_a = 0, m_sc_b = 0, m_fc_b = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit e_frz();
        if (m_wait) return !sram_ready;
        if (m_rec)  return 1'b0;
        return mem_req && !sram_ready;
    endfunction

    function automatic bit e_flush();
        return !e_frz() && branch_taken;
    endfunction

    function automatic bit e_fif();
        return !e_frz() && !branch_taken && hazard_detected;
    endfunction

    function automatic bit e_bubble();
        return !e_frz() && (branch_taken || hazard_detected);
    endfunction

    function automatic logic [1:0] e_state();
        if (m_wait) return 2'(MEM_WAIT);
        if (m_rec)  return 2'(RECOVER);
        return 2'(RUN);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait <= 0; m_rec <= 0; m_to <= 0; m_wlen <= 0;
            m_sc_a <= 0; m_fc_a <= 0; m_sc_b <= 0; m_fc_b <= 0;
        end else begin
            m_sc_a <= sat(m_sc_a + int'(e_frz() || e_fif()), MAX_A);
            m_sc_b <= sat(m_sc_b + int'(e_frz() || e_fif()), MAX_B);
            m_fc_a <= sat(m_fc_a + int'(e_flush()), MAX_A);
            m_fc_b <= sat(m_fc_b + int'(e_flush()), MAX_B);
            if (m_wait) begin
                m_wlen <= m_wlen + 1;
                if (m_wlen + 1 >= TO) m_to <= 1;
                if (sram_ready) begin
                    m_wait <= 0;
                    m_rec  <= 1;
                end
            end else if (m_rec) begin
                m_rec <= 0;
            end else if (mem_req && !sram_ready) begin
                m_wait <= 1;
                m_wlen <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("a.freeze_all",   fa_a, e_frz());
        chk("a.freeze_if",    fi_a, e_fif());
        chk("a.flush_if_id",  fl_a, e_flush());
        chk("a.bubble_id_ex", bb_a, e_bubble());
        chk("a.state",        st_a, e_state());
        chk("a.mem_timeout",  to_a, m_to);
        chk("a.stall_cycles", sc_a, m_sc_a);
        chk("a.flush_count",  fc_a, m_fc_a);
        chk("b.freeze_all",   fa_b, e_frz());
        chk("b.freeze_if",    fi_b, e_fif());
        chk("b.flush_if_id",  fl_b, e_flush());
        chk("b.bubble_id_ex", bb_b, e_bubble());
        chk("b.state",        st_b, e_state());
        chk("b.mem_timeout",  to_b, m_to);
        chk("b.stall_cycles", sc_b, m_sc_b);
        chk("b.flush_count",  fc_b, m_fc_b);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic h, input logic b, input logic m, input logic s);
        @(posedge clk);
        #1;
        hazard_detected = h;
        branch_taken    = b;
        mem_req         = m;
        sram_ready      = s;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        hazard_detected = 0; branch_taken = 0; mem_req = 0; sram_ready = 0;
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    logic [3:0] mix_vec [16] = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b0010, 4'b1111,
                                 4'b0100, 4'b0011, 4'b1000, 4'b0110, 4'b0111, 4'b0000,
                                 4'b1010, 4'b1001, 4'b0100, 4'b0000};

    initial begin
        int nfrz;
        #2 rst = 0;
        @(negedge clk);
        chk("reset.state", st_a, 2'(RUN));
        chk("reset.stall", sc_a, 0);
        chk("reset.flush", fc_a, 0);
        chk("reset.timeout", to_a, 0);
        @(posedge clk); #1 rst = 1;

        // hazard only
        cyc(1, 0, 0, 0); chk("haz1.freeze_if", fi_a, 1); chk("haz1.bubble", bb_a, 1);
        cyc(1, 0, 0, 0); chk("haz2.freeze_if", fi_a, 1); chk("haz2.bubble", bb_a, 1);
        cyc(0, 0, 0, 0); chk("haz.stall", sc_a, 2); chk("haz.flush", fc_a, 0);

        // branch with hazard
        do_reset();
        cyc(1, 1, 0, 0);
        chk("brh.flush", fl_a, 1); chk("brh.bubble", bb_a, 1); chk("brh.freeze_if", fi_a, 0);
        cyc(0, 0, 0, 0); chk("brh.flush_count", fc_a, 1);

        // memory miss, with a miss presented during RECOVER
        do_reset();
        nfrz = 0;
        cyc(0, 0, 1, 0); nfrz += int'(fa_a); chk("miss1.state", st_a, 2'(RUN));
        cyc(0, 0, 1, 0); nfrz += int'(fa_a); chk("miss2.state", st_a, 2'(MEM_WAIT));
        cyc(0, 0, 1, 0); nfrz += int'(fa_a); chk("miss3.state", st_a, 2'(MEM_WAIT));
        cyc(0, 0, 1, 1); nfrz += int'(fa_a); chk("miss.ready_unfrozen", fa_a, 0);
        cyc(0, 0, 1, 0); nfrz += int'(fa_a); chk("miss.recover", st_a, 2'(RECOVER));
        chk("miss.recover_nofreeze", fa_a, 0);
        cyc(0, 0, 0, 0); nfrz += int'(fa_a); chk("miss.run", st_a, 2'(RUN));
        chk("miss.freeze_cycles", nfrz, 3);
        chk("miss.stall", sc_a, 3);

        // branch held through a 2-cycle miss
        do_reset();
        cyc(0, 1, 1, 0); chk("bw1.flush", fl_a, 0);
        cyc(0, 1, 1, 0); chk("bw2.flush", fl_a, 0);
        cyc(0, 1, 1, 1); chk("bw3.flush", fl_a, 1);
        cyc(0, 0, 0, 0); chk("bw.flush_count", fc_a, 1);

        // timeout
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        chk("to.before", to_a, 0);
        cyc(0, 0, 1, 0); chk("to.set", to_a, 1);
        cyc(0, 0, 1, 1); chk("to.held_ready", to_a, 1);
        cyc(0, 0, 0, 0); chk("to.held_recover", to_a, 1);
        @(posedge clk); #3 rst = 0; #1;
        chk("to.reset_clears", to_a, 0);
        @(posedge clk); #1 rst = 1;

        // saturation and reset in MEM_WAIT
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sat.stall_b", sc_b, 3);
        chk("sat.stall_a", sc_a, 5);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0); chk("rmw.state_before", st_b, 2'(MEM_WAIT));
        @(posedge clk); #3 rst = 0; #1;
        chk("rmw.state", st_b, 2'(RUN));
        chk("rmw.stall_b", sc_b, 0);
        chk("rmw.flush_b", fc_b, 0);
        chk("rmw.stall_a", sc_a, 0);
        @(posedge clk); #1 rst = 1;
        mem_req = 0;
        cyc(0, 0, 0, 0); chk("rmw.no_recover", st_a, 2'(RUN));

        // mixed vectors, checked by the per-cycle compare
        for (int i = 0; i < 16; i++)
            cyc(mix_vec[i][3], mix_vec[i][2], mix_vec[i][1], mix_vec[i][0]);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
